// File: rtl/hack_mem_pkg.sv
// hack_mem_pkg: shared definitions for the hack_soc QSPI SRAM path.
//   HACK_WORD_W  : Hack data word width
//   SRAM_ADDR_W  : byte address width of the 23LC1024 (128 KiB)
//   arb_state_t  : arbiter FSM states
package hack_mem_pkg;

    localparam int HACK_WORD_W = 16;
    localparam int SRAM_ADDR_W = 17;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESPOND
    } arb_state_t;

endpackage

// File: rtl/rr_grant_picker.sv
// rr_grant_picker: combinational round-robin winner search.
//   valid     in  NUM_PORTS  request vector
//   last      in  IDX_W      index of the previous grant
//   winner    out NUM_PORTS  one-hot winner (zero when nothing is valid)
//   any_valid out 1          at least one request present
// The search starts one past `last` and wraps, so `last` itself has the
// lowest priority.
module rr_grant_picker #(
    parameter int NUM_PORTS = 3,
    parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] valid,
    input  logic [IDX_W-1:0]     last,
    output logic [NUM_PORTS-1:0] winner,
    output logic                 any_valid
);

    logic             found;
    logic [IDX_W-1:0] pos;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        pos    = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            pos = IDX_W'((int'(last) + i) % NUM_PORTS);
            if (!found && valid[pos]) begin
                winner[pos] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign any_valid = |valid;

endmodule

// File: rtl/qspi_ram_arbiter.sv
// qspi_ram_arbiter: round-robin arbiter sharing one QSPI SRAM controller
// between word-wide requesters, with optional bounded burst locking.
//   clk, reset                 clock, async active-low reset
//   req_valid/we/lock          per-port request, write enable, lock hint
//   req_addr/req_wdata         flattened per-port fields (port i at i*W +: W)
//   req_ready                  one-cycle accept pulse (one-hot)
//   rsp_valid/rsp_rdata        one-cycle completion pulse (one-hot) + data
//   mem_start/we/addr/wdata    transaction to the controller, held until done
//   mem_done/mem_rdata         completion + read data from the controller
//   busy                       high whenever the FSM is not IDLE
// All outputs are registered; the winner pick is internal combinational logic.
module qspi_ram_arbiter
    import hack_mem_pkg::*;
#(
    parameter int NUM_PORTS  = 3,
    parameter int ADDR_WIDTH = SRAM_ADDR_W,
    parameter int DATA_WIDTH = HACK_WORD_W,
    parameter int MAX_BURST  = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            req_valid,
    input  logic [NUM_PORTS-1:0]            req_we,
    input  logic [NUM_PORTS-1:0]            req_lock,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]            req_ready,
    output logic [NUM_PORTS-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            mem_start,
    output logic                            mem_we,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    input  logic                            mem_done,
    input  logic [DATA_WIDTH-1:0]           mem_rdata,
    output logic                            busy
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int BC_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    // Highest burst_cnt value that still allows one more locked re-grant.
    localparam logic [BC_W-1:0] BURST_LIM = BC_W'(MAX_BURST - 1);

    arb_state_t           state;
    logic [IDX_W-1:0]     last_grant;
    logic [BC_W-1:0]      burst_cnt;
    logic [NUM_PORTS-1:0] grant;

    logic [NUM_PORTS-1:0]  rr_winner;
    logic                  rr_any;
    logic                  lock_hit;
    logic [NUM_PORTS-1:0]  pick_oh;
    logic                  pick_any;
    logic [IDX_W-1:0]      pick_idx;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    rr_grant_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .valid     (req_valid),
        .last      (last_grant),
        .winner    (rr_winner),
        .any_valid (rr_any)
    );

    // A lock only counts while its owner is still requesting and the burst
    // budget is not exhausted; otherwise fall back to round-robin.
    assign lock_hit = req_lock[last_grant] & req_valid[last_grant] &
                      (burst_cnt < BURST_LIM);

    always_comb begin
        pick_oh  = rr_winner;
        pick_any = rr_any;
        if (lock_hit) begin
            pick_oh             = '0;
            pick_oh[last_grant] = 1'b1;
            pick_any            = 1'b1;
        end
    end

    always_comb begin
        pick_idx  = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (pick_oh[i]) begin
                pick_idx  = IDX_W'(i);
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign sel_we = |(req_we & pick_oh);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= IDX_W'(NUM_PORTS - 1);
            burst_cnt  <= '0;
            grant      <= '0;
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            mem_start  <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle.
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            mem_start <= 1'b0;

            case (state)
                IDLE, RESPOND: begin
                    if (pick_any) begin
                        // Grant taken here: fields are frozen from this edge.
                        grant      <= pick_oh;
                        last_grant <= pick_idx;
                        burst_cnt  <= lock_hit ? burst_cnt + BC_W'(1) : '0;
                        mem_we     <= sel_we;
                        mem_addr   <= sel_addr;
                        mem_wdata  <= sel_wdata;
                        mem_start  <= 1'b1;
                        req_ready  <= pick_oh;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (mem_done) begin
                        rsp_valid <= grant;
                        rsp_rdata <= mem_we ? '0 : mem_rdata;
                        state     <= RESPOND;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/qspi_ram_arbiter.md
# qspi_ram_arbiter

Shares the single QSPI serial SRAM controller of `hack_soc` (23LC1024, 128 KiB) between several word-wide requesters: CPU data port, ROM loader and display fetch. It is a round-robin arbiter with optional bounded burst locking and a start/done handshake to the downstream controller. It sits between the requesters and the QSPI controller that drives `ram_cs_n`/`ram_sck`/`ram_sio*`; this block has no pin-level logic.

## Interface
- `NUM_PORTS`, default 3: number of requesters; port 0 is the CPU.
- `ADDR_WIDTH`, default 17: byte address into the SRAM.
- `DATA_WIDTH`, default 16: Hack word.
- `MAX_BURST`, default 4: maximum consecutive grants to one locked port; 1 disables locking.
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_PORTS  per-port request.
- `req_we`  in  NUM_PORTS  per-port write enable.
- `req_lock`  in  NUM_PORTS  per-port request to keep the grant for the next transaction.
- `req_addr`  in  NUM_PORTS*ADDR_WIDTH  flattened; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_wdata`  in  NUM_PORTS*DATA_WIDTH  flattened, same packing.
- `req_ready`  out  NUM_PORTS  one-cycle accept pulse, at most one bit set.
- `rsp_valid`  out  NUM_PORTS  one-cycle completion pulse, at most one bit set.
- `rsp_rdata`  out  DATA_WIDTH  read data; valid while `rsp_valid` is non-zero.
- `mem_start`  out  1  one-cycle transaction start to the controller.
- `mem_we`, `mem_addr`, `mem_wdata`  out  1 / ADDR_WIDTH / DATA_WIDTH  transaction fields, held stable from `mem_start` until `mem_done`.
- `mem_done`  in  1  one-cycle completion from the controller.
- `mem_rdata`  in  DATA_WIDTH  read data, valid with `mem_done`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE: if any `req_valid` is set, pick a winner, latch its grant and fields, and go to ISSUE.
  - ISSUE: assert `mem_start`, pulse the winner's `req_ready`, go to WAIT.
  - WAIT: hold until `mem_done`, then register `mem_rdata` and go to RESPOND.
  - RESPOND: pulse `rsp_valid[g]` and drive `rsp_rdata`. In the same cycle, pick the next winner and go to ISSUE; if no request is pending, go to IDLE.
- Winner selection:
  - Locked re-grant: if the last grant g has `req_lock[g]` and `req_valid[g]` high and `burst_cnt < MAX_BURST-1`, re-grant g and increment `burst_cnt`.
  - Round-robin otherwise: search from (g+1) mod NUM_PORTS upward with wrap-around; `burst_cnt` clears to 0.
  - After reset the search starts at port 0.
- Field latching: fields are latched on the cycle the grant is taken. Changes on requester inputs after that cycle are ignored.
- Requester protocol: hold `req_valid` and fields until `req_ready`. Dropping `req_valid` early is illegal; the latched transaction completes anyway.
- Writes also produce a `rsp_valid` pulse. `rsp_rdata` is don't-care for writes and is driven 0.
- `mem_done` outside WAIT is ignored; the controller never completes in fewer than 2 cycles after `mem_start`.
- A `req_lock` held on a port with `req_valid` low has no effect; arbitration proceeds round-robin.

## Timing
- Reset values: state IDLE, all outputs 0 (`req_ready`, `rsp_valid`, `rsp_rdata`, `mem_start`, `mem_we`, `mem_addr`, `mem_wdata`, `busy`), last grant = NUM_PORTS-1, `burst_cnt` = 0.
- Reset asserted mid-transaction aborts it immediately with no `rsp_valid`. The controller shares `reset` and aborts in step.
- From IDLE, with `req_valid` rising at edge 0:
  - grant latched at edge 1;
  - `mem_start` and `req_ready` high during cycle 1–2;
  - `mem_done` at cycle k gives `rsp_valid` in cycle k+1.
- Back-to-back: the next `mem_start` follows `rsp_valid` by one cycle, with no IDLE bubble.
- All outputs are registered. The winner pick is combinational inside the block and is never exposed on a port.

## Structure
- Shared package `hack_mem_pkg`:
  - state enum (IDLE, ISSUE, WAIT, RESPOND);
  - `HACK_WORD_W` = 16;
  - `SRAM_ADDR_W` = 17.
- One sub-module: `rr_grant_picker`, a combinational function of (valid vector, last grant) returning a one-hot winner and an any-valid flag. The lock override stays in the parent.

## Test plan
- Single read: port 1 reads 0x00010, controller returns 0xBEEF three cycles after `mem_start` → one `req_ready[1]` pulse; `rsp_valid` = 3'b010 with `rsp_rdata` = 0xBEEF in the cycle after `mem_done`.
- Contention: ports 0, 1 and 2 all valid continuously, no lock → grant order 0,1,2,0,1,2. `mem_start` spacing equals controller latency + 2.
- Burst lock, MAX_BURST=4: port 2 holds lock and valid, port 0 also valid → four consecutive grants to 2, then 0, then 2 again; `burst_cnt` returns to 0.
- Write: port 0 writes 0x1234 to 0x1FFFE → `mem_we`=1, `mem_addr`=0x1FFFE and `mem_wdata`=0x1234 stable through WAIT; `rsp_valid[0]` pulses with `rsp_rdata`=0.
- Reset mid-WAIT: drop `reset` low while in WAIT → all outputs 0 asynchronously and no `rsp_valid`. After release, the first grant goes to the lowest valid port.
- Stray `mem_done` in IDLE and ISSUE → no state change and no `rsp_valid`.
